// File: rtl/prod_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
package prod_acc_pkg;

    localparam int DEF_PROD_W  = 8;
    localparam int DEF_ACC_W   = 12;
    localparam int DEF_MAX_LEN = 16;

    // Width of the burst-length field on the input interface.
    localparam int LEN_PORT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/prod_accumulator_sat_adder.sv
// Unsigned accumulate step: adds a product to the running sum one bit wider
// than the sum, and clamps to all-ones when the carry comes out.
module sat_adder #(
    parameter int ACC_W  = 12,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam int SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] wide;

    // Widened add; the top bit is the overflow flag and selects saturation.
    always_comb begin
        wide = SUM_W'(a) + SUM_W'(b);
        ovf  = wide[ACC_W];
        sum  = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/prod_accumulator.sv
// Burst accumulator: sums a variable-length burst of unsigned products and
// presents the saturated total plus a sticky overflow flag on a valid/ready
// output. Bursts never overlap; the input stalls while a result is held.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_W-1:0]     in_prod,
    input  logic [LEN_PORT_W-1:0] in_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_ovf
);

    // Counter must hold both MAX_LEN and any in_len value for comparison.
    localparam int CNT_W = ($clog2(MAX_LEN + 1) > LEN_PORT_W) ? $clog2(MAX_LEN + 1) : LEN_PORT_W;
    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic             ready_en;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic             ovf;

    logic             beat_fire;
    logic             result_fire;
    logic [CNT_W-1:0] in_len_ext;
    logic [CNT_W-1:0] first_len;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // The first beat starts from zero so one adder serves load and accumulate.
    sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .a   (add_a),
        .b   (in_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Handshake decode, burst-length clamping and adder operand selection.
    always_comb begin
        beat_fire   = in_valid & in_ready;
        result_fire = out_valid & out_ready;
        in_len_ext  = CNT_W'(in_len);
        first_len   = ((in_len_ext == '0) || (in_len_ext > MAX_LEN_C)) ? MAX_LEN_C : in_len_ext;
        cnt_inc     = cnt + ONE_C;
        add_a       = (state == ACCUM) ? acc : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Keeps in_ready low during reset and until the first clock edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Next-state logic: load, accumulate until len beats, hold until taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (beat_fire) begin
                    next_state = (first_len == ONE_C) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_fire && (cnt_inc == len)) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (result_fire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Burst datapath: sum, beat count, latched length and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (beat_fire) begin
            if (state == IDLE) begin
                acc <= add_sum;
                cnt <= ONE_C;
                len <= first_len;
                ovf <= 1'b0;
            end else begin
                acc <= add_sum;
                cnt <= cnt_inc;
                ovf <= ovf | add_ovf;
            end
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        in_ready  = ready_en && (state != HOLD);
        out_valid = (state == HOLD);
        out_sum   = acc;
        out_ovf   = ovf;
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: a default-width instance and an
// 8-bit-sum instance share all inputs, so saturation can be observed on the
// narrow one while the wide one carries exact sums.
module tb_prod_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic [4:0]  in_len;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        out_ovf;

    logic        nar_in_ready;
    logic        nar_out_valid;
    logic [7:0]  nar_out_sum;
    logic        nar_out_ovf;

    int total;
    int bad;

    prod_accumulator #(
        .PROD_W  (8),
        .ACC_W   (12),
        .MAX_LEN (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    prod_accumulator #(
        .PROD_W  (8),
        .ACC_W   (8),
        .MAX_LEN (16)
    ) dut_narrow (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (nar_in_ready),
        .in_prod   (in_prod),
        .in_len    (in_len),
        .out_valid (nar_out_valid),
        .out_ready (out_ready),
        .out_sum   (nar_out_sum),
        .out_ovf   (nar_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: running sum clamped at 2^w-1, flag set if ever clamped.
    function automatic void model(input int prods[$], input int w, output int s, output bit o);
        int lim;
        lim = (1 << w) - 1;
        s = 0;
        o = 1'b0;
        foreach (prods[i]) begin
            s = s + prods[i];
            if (s > lim) begin
                s = lim;
                o = 1'b1;
            end
        end
    endfunction

    // Presents one beat and returns #1 after the edge on which it transferred.
    task automatic drive_beat(input logic [7:0] prod, input logic [4:0] len);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_prod  = prod;
        in_len   = len;
        while (!in_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL beat_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Stalls out_ready, then takes the result; returns #1 after the transfer edge.
    task automatic collect(input int stall, output logic [11:0] s, output logic o,
                           output logic [7:0] sn, output logic on_, output bit got);
        int w;
        w = 0;
        out_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        while (!out_valid && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        got = out_valid;
        s   = out_sum;
        o   = out_ovf;
        sn  = nar_out_sum;
        on_ = nar_out_ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_len = '0; out_ready = 1'b0;
        #3;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("[TB] FAIL rst_in_ready: got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("[TB] FAIL rst_out_valid: got=%0b want=0", out_valid); end
        total++; if (out_sum !== 12'd0)   begin bad++; $display("[TB] FAIL rst_out_sum: got=%0d want=0", out_sum); end
        total++; if (out_ovf !== 1'b0)    begin bad++; $display("[TB] FAIL rst_out_ovf: got=%0b want=0", out_ovf); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("[TB] FAIL rel_in_ready_early: got=%0b want=0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1)   begin bad++; $display("[TB] FAIL rel_in_ready: got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("[TB] FAIL rel_out_valid: got=%0b want=0", out_valid); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive_beat(8'd15, 5'd4);
        drive_beat(8'd30, 5'd4);
        drive_beat(8'd45, 5'd4);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid: got=%0b want=0", out_valid); end
        drive_beat(8'd225, 5'd4);
        total++; if (out_valid !== 1'b1)    begin bad++; $display("[TB] FAIL basic_latency: got=%0b want=1", out_valid); end
        total++; if (out_sum !== 12'd315)   begin bad++; $display("[TB] FAIL basic_sum: got=%0d want=315", out_sum); end
        total++; if (out_ovf !== 1'b0)      begin bad++; $display("[TB] FAIL basic_ovf: got=%0b want=0", out_ovf); end
        total++; if (nar_out_sum !== 8'd255) begin bad++; $display("[TB] FAIL basic_narrow_sum: got=%0d want=255", nar_out_sum); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0)    begin bad++; $display("[TB] FAIL basic_release: got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1)     begin bad++; $display("[TB] FAIL basic_idle_ready: got=%0b want=1", in_ready); end
    endtask

    task automatic test_max_len;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_beat(8'd225, (i == 0) ? 5'd0 : 5'(i));
            if (i == 14) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL maxlen_early_valid: got=%0b want=0", out_valid); end
            end
        end
        total++; if (out_valid !== 1'b1)   begin bad++; $display("[TB] FAIL maxlen_valid: got=%0b want=1", out_valid); end
        total++; if (in_ready !== 1'b0)    begin bad++; $display("[TB] FAIL maxlen_hold_ready: got=%0b want=0", in_ready); end
        total++; if (out_sum !== 12'd3600) begin bad++; $display("[TB] FAIL maxlen_sum: got=%0d want=3600", out_sum); end
        total++; if (out_ovf !== 1'b0)     begin bad++; $display("[TB] FAIL maxlen_ovf: got=%0b want=0", out_ovf); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0)   begin bad++; $display("[TB] FAIL maxlen_release: got=%0b want=0", out_valid); end
    endtask

    task automatic test_saturate;
        out_ready = 1'b0;
        drive_beat(8'd200, 5'd2);
        drive_beat(8'd100, 5'd2);
        total++; if (nar_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL sat_valid: got=%0b want=1", nar_out_valid); end
        total++; if (nar_out_sum !== 8'd255) begin bad++; $display("[TB] FAIL sat_sum: got=%0d want=255", nar_out_sum); end
        total++; if (nar_out_ovf !== 1'b1)   begin bad++; $display("[TB] FAIL sat_ovf: got=%0b want=1", nar_out_ovf); end
        total++; if (out_sum !== 12'd300)    begin bad++; $display("[TB] FAIL sat_wide_sum: got=%0d want=300", out_sum); end
        total++; if (out_ovf !== 1'b0)       begin bad++; $display("[TB] FAIL sat_wide_ovf: got=%0b want=0", out_ovf); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_gaps;
        int prods[$];
        int es;
        bit eo;
        logic [7:0] p;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p = 8'($urandom_range(0, 225));
            prods.push_back(int'(p));
            drive_beat(p, (i == 0) ? 5'd3 : 5'($urandom_range(0, 31)));
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        model(prods, 12, es, eo);
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1)     begin bad++; $display("[TB] FAIL gaps_hold_valid[%0d]: got=%0b want=1", c, out_valid); end
            total++; if (out_sum !== 12'(es))    begin bad++; $display("[TB] FAIL gaps_hold_sum[%0d]: got=%0d want=%0d", c, out_sum, es); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL gaps_release: got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL gaps_idle_ready: got=%0b want=1", in_ready); end
    endtask

    task automatic test_reset_midburst;
        out_ready = 1'b1;
        drive_beat(8'd50, 5'd4);
        drive_beat(8'd60, 5'd4);
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ready: got=%0b want=0", in_ready); end
        total++; if (out_sum !== 12'd0) begin bad++; $display("[TB] FAIL midrst_sum: got=%0d want=0", out_sum); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale[%0d]: got=%0b want=0", c, out_valid); end
        end
        drive_beat(8'd9, 5'd1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_new_valid: got=%0b want=1", out_valid); end
        total++; if (out_sum !== 12'd9)  begin bad++; $display("[TB] FAIL midrst_new_sum: got=%0d want=9", out_sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int hs;
        hs = 0;
        out_ready = 1'b1;
        drive_beat(8'd0, 5'd1);
        total++; if (out_sum !== 12'd0) begin bad++; $display("[TB] FAIL zero_sum: got=%0d want=0", out_sum); end
        for (int c = 0; c < 5; c++) begin
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        total++; if (hs != 1) begin bad++; $display("[TB] FAIL zero_handshakes: got=%0d want=1", hs); end
    endtask

    task automatic test_back_to_back;
        int prods[$];
        int lenv, eff, es, en;
        bit eo, eno, got;
        logic [7:0] p;
        logic [11:0] s;
        logic o, on_;
        logic [7:0] sn;
        for (int b = 0; b < 25; b++) begin
            prods.delete();
            lenv = $urandom_range(0, 31);
            eff  = (lenv == 0 || lenv > 16) ? 16 : lenv;
            for (int k = 0; k < eff; k++) begin
                p = 8'($urandom_range(0, 255));
                prods.push_back(int'(p));
                drive_beat(p, (k == 0) ? 5'(lenv) : 5'($urandom_range(0, 31)));
                if (k < eff - 1 && $urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rnd_latency[%0d]: got=%0b want=1", b, out_valid); end
            collect($urandom_range(0, 3), s, o, sn, on_, got);
            model(prods, 12, es, eo);
            model(prods, 8, en, eno);
            total++; if (!got)            begin bad++; $display("[TB] FAIL rnd_timeout[%0d]: got=0 want=1", b); end
            total++; if (s !== 12'(es))   begin bad++; $display("[TB] FAIL rnd_sum[%0d]: got=%0d want=%0d", b, s, es); end
            total++; if (o !== eo)        begin bad++; $display("[TB] FAIL rnd_ovf[%0d]: got=%0b want=%0b", b, o, eo); end
            total++; if (sn !== 8'(en))   begin bad++; $display("[TB] FAIL rnd_nsum[%0d]: got=%0d want=%0d", b, sn, en); end
            total++; if (on_ !== eno)     begin bad++; $display("[TB] FAIL rnd_novf[%0d]: got=%0b want=%0b", b, on_, eno); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_max_len();
        test_saturate();
        test_gaps();
        test_reset_midburst();
        test_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter PROD_W, default 8, SHALL set the width of the unsigned input product.
REQ-002 Parameter ACC_W, default 12, SHALL set the width of the accumulated sum.
REQ-003 Parameter MAX_LEN, default 16, SHALL set the maximum number of products per burst.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 in_valid  input  1  SHALL indicate that in_prod and in_len carry a valid beat.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-008 in_prod  input  PROD_W  SHALL carry the unsigned product from the upstream 4x4 multiplier.
REQ-009 in_len  input  5  SHALL carry the burst length; it is sampled only on the first beat of a burst.
REQ-010 out_valid  output  1  SHALL indicate that out_sum and out_ovf are valid.
REQ-011 out_ready  input  1  SHALL indicate that the downstream consumer accepts the result.
REQ-012 out_sum  output  ACC_W  SHALL carry the accumulated sum of the burst.
REQ-013 out_ovf  output  1  SHALL be set when any partial sum of the burst exceeded 2^ACC_W-1.

Function
REQ-014 A beat SHALL transfer only in a cycle where in_valid=1 and in_ready=1; a result SHALL transfer only in a cycle where out_valid=1 and out_ready=1.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0; an accepted beat SHALL perform the following:
- load acc=in_prod, cnt=1, ovf=0;
- latch len = (in_len==0 or in_len>MAX_LEN) ? MAX_LEN : in_len;
- go to HOLD if len==1, else go to ACCUM.
REQ-017 In ACCUM, in_ready SHALL be 1; each accepted beat SHALL perform the following:
- acc = acc + in_prod, computed at width ACC_W+1;
- on a carry out, set ovf and hold acc at 2^ACC_W-1 (saturate);
- cnt = cnt + 1; go to HOLD when cnt reaches len.
REQ-018 In ACCUM, a cycle with no accepted beat SHALL leave acc, cnt and ovf unchanged.
REQ-019 In HOLD, out_valid SHALL be 1, in_ready 0, and out_sum/out_ovf SHALL hold stable until the result transfers; on transfer the FSM SHALL return to IDLE.
REQ-020 out_valid SHALL rise exactly one cycle after the final beat is accepted, i.e. latency 1.
REQ-021 Bursts SHALL NOT overlap: the first beat of the next burst is accepted no earlier than the cycle after the result transfers.
REQ-022 in_ready SHALL be driven by state only, with no combinational path from out_ready or in_valid.
REQ-023 in_len values on non-first beats SHALL be ignored.
REQ-024 With the defaults, 16 x 225 = 3600 < 4096, so out_ovf SHALL never assert for 4x4 products.

Reset
REQ-025 While rst_n=0, the block SHALL force the following, independent of clk:
- state IDLE; acc, cnt, len and ovf = 0;
- out_valid = 0, out_sum = 0, out_ovf = 0, in_ready = 0.
REQ-026 in_ready SHALL assert on the first rising edge after rst_n deasserts.
REQ-027 Reset asserted mid-burst or in HOLD SHALL discard the partial burst; no result SHALL be emitted for it.

Structure
REQ-028 Package prod_acc_pkg SHALL hold the following:
- the state enum {IDLE, ACCUM, HOLD};
- the default constants PROD_W, ACC_W and MAX_LEN.
REQ-029 Sub-module sat_adder (ACC_W-bit unsigned add, with saturate and overflow outputs) SHALL implement the accumulate datapath; the FSM and counters SHALL remain in prod_accumulator.

Verification
REQ-030 Bench SHALL cover: in_len=4, products 15, 30, 45, 225 back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=315, out_ovf=0.
REQ-031 Bench SHALL cover: in_len=0, sixteen beats of 225 -> out_sum=3600, out_ovf=0, and in_ready=0 in the HOLD cycle.
REQ-032 Bench SHALL cover: ACC_W=8, in_len=2, products 200 and 100 -> out_sum=255, out_ovf=1.
REQ-033 Bench SHALL cover: in_len=3 with in_valid gaps, and out_ready held at 0 for 5 cycles -> out_sum=sum of the beats, stable for all 5 cycles, then one transfer and return to IDLE.
REQ-034 Bench SHALL cover: rst_n pulsed low after 2 of 4 beats, then a new burst with in_len=1 and product 9 -> out_sum=9; no stale result emitted.
REQ-035 Bench SHALL cover: in_len=1, product 0 -> out_sum=0, out_valid for exactly one handshake.
